// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture
//  Purpose  : Single-shot trace buffer. A live packed control word is
//             registered onto q every cycle. After arm, trig captures the
//             word into entry 0, and each following cycle appends the word
//             until the buffer is full or stop is seen. Once DONE, the entries
//             are popped in order through a valid/ready readout port.
//  Config   : define TRACE_CHANGE_ONLY_EN to append a word during capture
//             only when it differs from the last entry written. The trigger
//             entry is always written.
//  Ports    : clk, reset (async, active-low)
//             input_a/b/c [FIELD_W], cin, rec[2], pc_en, reg_en : traced fields
//             arm, trig, stop                                   : capture control
//             rd_ready                                          : readout pop
//             q[W]     : registered live packed word
//             state[2] : IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//             count[CW], full : buffer fill level
//             rd_valid, rd_data[W] : readout entry at the read pointer
//  Revision : 1.0  initial release
// ============================================================================
module trace_capture #(
  parameter  int FIELD_W = 4,
  parameter  int DEPTH   = 8,
  localparam int W       = 3*FIELD_W + 5,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FIELD_W-1:0] input_a,
  input  logic [FIELD_W-1:0] input_b,
  input  logic [FIELD_W-1:0] input_c,
  input  logic               cin,
  input  logic [1:0]         rec,
  input  logic               pc_en,
  input  logic               reg_en,
  input  logic               arm,
  input  logic               trig,
  input  logic               stop,
  input  logic               rd_ready,
  output logic [W-1:0]       q,
  output logic [1:0]         state,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               rd_valid,
  output logic [W-1:0]       rd_data
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [W-1:0]  pword;
  logic [1:0]    state_nxt;
  logic          wr_en;
  logic          pop;
  logic          change_ok;
  logic [CW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];

  assign pword = {input_a, input_b, cin, input_c, rec, pc_en, reg_en};

`ifdef TRACE_CHANGE_ONLY_EN
  // Copy of the most recently written entry, so the comparison does not need
  // a second read port on the storage array.
  logic [W-1:0] last_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_wr <= '0;
    end else if (wr_en) begin
      last_wr <= pword;
    end
  end

  assign change_ok = (pword != last_wr);
`else
  assign change_ok = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Write qualification. ARMED is only ever entered through arm, which clears
  // count, so the trigger write naturally lands in entry 0.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_en = 1'b0;
    case (state)
      ARMED:   wr_en = trig && !arm;
      CAPTURE: wr_en = !arm && !stop && change_ok && (count < DEPTH_C);
      default: wr_en = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic; arm overrides everything else in every state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (trig) state_nxt = CAPTURE;
        end
        CAPTURE: begin
          if (stop) begin
            state_nxt = DONE;
          end else if (wr_en && ((count + ONE_C) == DEPTH_C)) begin
            state_nxt = DONE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. rd_data is forced to zero when nothing is readable, so the
  // storage array never needs clearing on reset or arm.
  // --------------------------------------------------------------------------
  always_comb begin
    full     = (count == DEPTH_C);
    rd_valid = 1'b0;
    rd_data  = '0;
    if ((state == DONE) && (rd_ptr < count)) begin
      rd_valid = 1'b1;
      rd_data  = mem[rd_ptr[AW-1:0]];
    end
  end

  assign pop = rd_valid && rd_ready && !arm;

  // --------------------------------------------------------------------------
  // Live word, fill level and read pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= '0;
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      q <= pword;
      if (arm) begin
        count  <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) count  <= count + ONE_C;
        if (pop)   rd_ptr <= rd_ptr + ONE_C;
      end
    end
  end

  // Trace storage: contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count[AW-1:0]] <= pword;
    end
  end

endmodule
`default_nettype wire
